// File: rtl/rpn_token_sequencer.sv
// rpn_token_sequencer
//  Feeds a stack ALU from a postfix (RPN) token stream. Operands become
//  PUSH commands; ADD/MUL become a six-cycle ARITH/CAP/POP/POP/PUSHR
//  sequence; END pops the single surviving value and returns it.
//  Errors (operand underflow, stack full, bad END depth) are detected when
//  the token is accepted. The rest of the expression is then discarded and
//  the ALU stack is drained back to empty.
//
//  Optional feature macro: RPN_SEQ_PERF_EN
//   Adds output res_cycles[15:0]. It counts the cycles from the first
//   accepted token of an expression to the rise of res_valid. It saturates
//   and is cleared on the result handshake.
module rpn_token_sequencer #(
  parameter int N          = 16,
  parameter int STACK_SIZE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_value,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_data,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_ovf,
  output logic [1:0]   res_err
`ifdef RPN_SEQ_PERF_EN
  ,
  output logic [15:0]  res_cycles
`endif
);

  localparam int DW = $clog2(STACK_SIZE);

  // The ALU stack pointer wraps at STACK_SIZE, so one slot stays unusable.
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_SIZE - 1);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b100,
    OP_MUL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    TK_OPERAND = 2'b00,
    TK_ADD     = 2'b01,
    TK_MUL     = 2'b10,
    TK_END     = 2'b11
  } tok_kind_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_UNDER = 2'b01,
    ERR_FULL  = 2'b10,
    ERR_END   = 2'b11
  } err_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH,
    S_ARITH,
    S_CAP,
    S_POP1,
    S_POP2,
    S_PUSHR,
    S_FIN,
    S_SKIP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] depth;
  logic [DW-1:0] depth_nxt;
  logic [N-1:0]  acc;
  logic          accept;

  assign accept = tok_valid && tok_ready;

  // Depth after the opcode currently on the bus has executed in the ALU.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    depth_nxt = depth;
    if (alu_opcode == OP_PUSH) begin
      depth_nxt = depth + DEPTH_ONE;
    end else if (alu_opcode == OP_POP) begin
      depth_nxt = depth - DEPTH_ONE;
    end
  end

  // Depth follows the issued opcodes, so it moves on the same edge as the ALU sp.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else begin
      depth <= depth_nxt;
    end
  end

  // Control FSM. Opcode, data, ready and result outputs are all registered.
  // Any cycle that does not name an opcode issues NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tok_ready  <= 1'b0;
      alu_opcode <= OP_NOP;
      alu_data   <= '0;
      acc        <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      res_err    <= ERR_OK;
    end else begin
      tok_ready  <= 1'b0;
      alu_opcode <= OP_NOP;

      case (state)
        S_IDLE: begin
          tok_ready <= 1'b1;
          if (accept) begin
            tok_ready <= 1'b0;
            case (tok_kind)
              TK_OPERAND: begin
                if (depth == DEPTH_MAX) begin
                  res_err   <= ERR_FULL;
                  state     <= S_SKIP;
                  tok_ready <= 1'b1;
                end else begin
                  // acc follows the top of stack, so a lone operand can be returned by END.
                  state      <= S_PUSH;
                  alu_opcode <= OP_PUSH;
                  alu_data   <= tok_value;
                  acc        <= tok_value;
                end
              end
              TK_ADD, TK_MUL: begin
                if (depth < DEPTH_TWO) begin
                  res_err   <= ERR_UNDER;
                  state     <= S_SKIP;
                  tok_ready <= 1'b1;
                end else begin
                  state      <= S_ARITH;
                  alu_opcode <= (tok_kind == TK_MUL) ? OP_MUL : OP_ADD;
                end
              end
              TK_END: begin
                if (depth != DEPTH_ONE) begin
                  // END closes the expression itself, so drain straight away.
                  res_err    <= ERR_END;
                  state      <= S_DRAIN;
                  alu_opcode <= (depth != '0) ? OP_POP : OP_NOP;
                end else begin
                  state      <= S_FIN;
                  alu_opcode <= OP_POP;
                end
              end
            endcase
          end
        end

        S_PUSH: begin
          state     <= S_IDLE;
          tok_ready <= 1'b1;
        end

        S_ARITH: begin
          state <= S_CAP;
        end

        S_CAP: begin
          // The ALU registered the arithmetic result on the previous edge.
          acc        <= alu_result;
          res_ovf    <= res_ovf | alu_overflow;
          state      <= S_POP1;
          alu_opcode <= OP_POP;
        end

        S_POP1: begin
          state      <= S_POP2;
          alu_opcode <= OP_POP;
        end

        S_POP2: begin
          state      <= S_PUSHR;
          alu_opcode <= OP_PUSH;
          alu_data   <= acc;
        end

        S_PUSHR: begin
          state     <= S_IDLE;
          tok_ready <= 1'b1;
        end

        S_FIN: begin
          res_data  <= acc;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end

        S_SKIP: begin
          // An error is already recorded. Swallow tokens until END closes the expression.
          tok_ready <= 1'b1;
          if (accept && (tok_kind == TK_END)) begin
            tok_ready  <= 1'b0;
            state      <= S_DRAIN;
            alu_opcode <= (depth != '0) ? OP_POP : OP_NOP;
          end
        end

        S_DRAIN: begin
          if (depth_nxt != '0) begin
            alu_opcode <= OP_POP;
          end else begin
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
            res_err   <= ERR_OK;
            state     <= S_IDLE;
            tok_ready <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RPN_SEQ_PERF_EN
  logic perf_run;
  logic done_rise;

  assign done_rise = (state == S_FIN) || ((state == S_DRAIN) && (depth_nxt == '0));

  // Expression latency: starts on the first accepted token and stops when res_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cycles <= '0;
      perf_run   <= 1'b0;
    end else if ((state == S_DONE) && res_ready) begin
      res_cycles <= '0;
      perf_run   <= 1'b0;
    end else if (perf_run) begin
      if (res_cycles != 16'hFFFF) begin
        res_cycles <= res_cycles + 16'd1;
      end
      if (done_rise) begin
        perf_run <= 1'b0;
      end
    end else if (accept && (state == S_IDLE)) begin
      res_cycles <= '0;
      perf_run   <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rpn_token_sequencer.sv
// tb_rpn_token_sequencer
//  Directed scenarios plus randomized expressions. Expected results come
//  from a queue-based RPN evaluator. A behavioural stack ALU with
//  registered outputs and a signed-overflow flag sits on the command side.
`timescale 1ns/1ps
module tb_rpn_token_sequencer;
  localparam int N = 16;
  localparam int MAX_DEPTH = 15;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] K_OPD = 2'b00;
  localparam logic [1:0] K_ADD = 2'b01;
  localparam logic [1:0] K_MUL = 2'b10;
  localparam logic [1:0] K_END = 2'b11;

  typedef struct packed { logic [1:0] kind; logic [N-1:0] value; } tok_t;
  typedef struct packed { logic [N-1:0] data; logic ovf; logic [1:0] err; } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic [1:0]   tok_kind = 2'b00;
  logic [N-1:0] tok_value = '0;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_result;
  logic         alu_overflow;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] res_data;
  logic         res_ovf;
  logic [1:0]   res_err;
`ifdef RPN_SEQ_PERF_EN
  logic [15:0]  res_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  always #5 clk = ~clk;

  rpn_token_sequencer #(.N(N), .STACK_SIZE(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_kind     (tok_kind),
    .tok_value    (tok_value),
    .alu_opcode   (alu_opcode),
    .alu_data     (alu_data),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_ovf      (res_ovf),
    .res_err      (res_err)
`ifdef RPN_SEQ_PERF_EN
    ,
    .res_cycles   (res_cycles)
`endif
  );

  // ---------------- signed arithmetic helpers ----------------
  function automatic int to_int(input logic [N-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic add_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
    int s;
    s = to_int(a) + to_int(b);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic mul_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = to_int(a) * to_int(b);
    return (p > 32767) || (p < -32768);
  endfunction

  // ---------------- behavioural stack ALU ----------------
  logic [N-1:0] alu_stk [16];
  logic [3:0]   alu_sp;
  wire          alu_rst = ~rst_n;

  always @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      alu_sp       <= 4'd0;
      alu_result   <= '0;
      alu_overflow <= 1'b0;
    end else begin
      alu_overflow <= 1'b0;
      case (alu_opcode)
        OP_PUSH: begin
          alu_stk[alu_sp] <= alu_data;
          alu_sp          <= alu_sp + 4'd1;
        end
        OP_POP: begin
          alu_result <= alu_stk[alu_sp - 4'd1];
          alu_sp     <= alu_sp - 4'd1;
        end
        OP_ADD: begin
          alu_result   <= alu_stk[alu_sp - 4'd1] + alu_stk[alu_sp - 4'd2];
          alu_overflow <= add_ovf(alu_stk[alu_sp - 4'd1], alu_stk[alu_sp - 4'd2]);
        end
        OP_MUL: begin
          alu_result   <= alu_stk[alu_sp - 4'd1] * alu_stk[alu_sp - 4'd2];
          alu_overflow <= mul_ovf(alu_stk[alu_sp - 4'd1], alu_stk[alu_sp - 4'd2]);
        end
        default: ;
      endcase
    end
  end

  // Opcode counters sampled mid-cycle
  always @(negedge clk) begin
    if (alu_opcode == OP_PUSH) push_cnt++;
    if (alu_opcode == OP_POP)  pop_cnt++;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic res_t model(input tok_t q[$]);
    logic [N-1:0] stk[$];
    logic [N-1:0] a, b, r;
    res_t e;
    e = '0;
    foreach (q[i]) begin
      if (q[i].kind == K_END) begin
        if (e.err == 2'b00 && stk.size() != 1) e.err = 2'b11;
        break;
      end
      if (e.err != 2'b00) continue;
      if (q[i].kind == K_OPD) begin
        if (stk.size() == MAX_DEPTH) e.err = 2'b10;
        else stk.push_back(q[i].value);
      end else if (stk.size() < 2) begin
        e.err = 2'b01;
      end else begin
        a = stk.pop_back();
        b = stk.pop_back();
        if (q[i].kind == K_ADD) begin
          r = a + b;
          e.ovf = e.ovf | add_ovf(a, b);
        end else begin
          r = a * b;
          e.ovf = e.ovf | mul_ovf(a, b);
        end
        stk.push_back(r);
      end
    end
    e.data = (e.err == 2'b00) ? stk[$] : '0;
    return e;
  endfunction

  function automatic tok_t mk(input logic [1:0] kind, input logic [N-1:0] value);
    tok_t t;
    t.kind  = kind;
    t.value = value;
    return t;
  endfunction

  // ---------------- drivers (called at a negedge) ----------------
  task automatic send_tok(input tok_t t);
    int w;
    w = 0;
    tok_valid = 1'b1;
    tok_kind  = t.kind;
    tok_value = t.value;
    while (!tok_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!tok_ready) $display("FAIL tok_handshake: tok_ready=%0b after %0d cycles, want 1", tok_ready, w);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    int w;
    w = 0;
    while (!res_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    ok = res_valid;
    n_checks++;
    if (!ok) $display("FAIL res_timeout: res_valid=%0b after %0d cycles, want 1", res_valid, w);
    else n_pass++;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_expr(input tok_t q[$], input int gap_max, input int hold,
                          output res_t got, output bit ok);
    foreach (q[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_tok(q[i]);
    end
    wait_result(ok);
    got = {res_data, res_ovf, res_err};
    if (ok) begin
      repeat (hold) @(negedge clk);
      take_result();
    end
  endtask

  task automatic gen_expr(output tok_t q[$]);
    int d, len;
    tok_t t;
    q = {};
    d = 0;
    if ($urandom_range(0, 7) == 0) len = $urandom_range(14, 18);
    else len = $urandom_range(1, 8);
    for (int i = 0; i < len; i++) begin
      if (len > 12 || $urandom_range(0, 9) < 6) begin
        t.kind  = K_OPD;
        t.value = ($urandom_range(0, 1) == 1) ? N'($urandom) : N'($urandom_range(0, 20));
        d++;
      end else begin
        t.kind  = ($urandom_range(0, 1) == 1) ? K_ADD : K_MUL;
        t.value = N'($urandom);
        if (d >= 2) d--;
      end
      q.push_back(t);
    end
    if ($urandom_range(0, 3) != 0) begin
      while (d > 1) begin
        t.kind  = ($urandom_range(0, 1) == 1) ? K_ADD : K_MUL;
        t.value = '0;
        q.push_back(t);
        d--;
      end
    end
    q.push_back(mk(K_END, '0));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    n_checks++;
    if ({tok_ready, alu_opcode, alu_data, res_valid, res_data, res_ovf, res_err} !== '0)
      $display("FAIL reset_outputs: ready=%0b op=%b data=%h rv=%0b rd=%h ovf=%0b err=%b, want all 0",
               tok_ready, alu_opcode, alu_data, res_valid, res_data, res_ovf, res_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tok_ready !== 1'b1 || alu_opcode !== OP_NOP)
      $display("FAIL reset_idle: tok_ready=%0b op=%b, want 1 and 000", tok_ready, alu_opcode);
    else n_pass++;
  endtask

  task automatic test_add_timing();
    logic [2:0] seq [5];
    bit ok;
    seq = '{OP_ADD, OP_NOP, OP_POP, OP_POP, OP_PUSH};
    send_tok(mk(K_OPD, 16'd3));
    n_checks++;
    if (alu_opcode !== OP_PUSH || alu_data !== 16'd3)
      $display("FAIL push_latency: op=%b data=%h, want 110 and 0003", alu_opcode, alu_data);
    else n_pass++;
    send_tok(mk(K_OPD, 16'd4));
    send_tok(mk(K_ADD, '0));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (alu_opcode !== seq[i])
        $display("FAIL add_seq_T%0d: op=%b, want %b", i + 1, alu_opcode, seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (alu_data !== 16'd7) $display("FAIL pushr_data: got %h, want 0007", alu_data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tok_ready !== 1'b1 || alu_opcode !== OP_NOP)
      $display("FAIL add_idle_T6: tok_ready=%0b op=%b, want 1 and 000", tok_ready, alu_opcode);
    else n_pass++;
    send_tok(mk(K_END, '0));
    wait_result(ok);
    n_checks++;
    if ({res_data, res_ovf, res_err} !== {16'd7, 1'b0, 2'b00})
      $display("FAIL add_result: data=%h ovf=%0b err=%b, want 0007 0 00", res_data, res_ovf, res_err);
    else n_pass++;
    take_result();
    n_checks++;
    if (alu_sp !== 4'd0 || res_valid !== 1'b0)
      $display("FAIL add_final: sp=%0d res_valid=%0b, want 0 and 0", alu_sp, res_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    tok_t q[$];
    res_t got;
    bit ok;
    q = {mk(K_OPD, 16'h7FFF), mk(K_OPD, 16'h0001), mk(K_ADD, '0), mk(K_END, '0)};
    run_expr(q, 0, 0, got, ok);
    n_checks++;
    if (got !== {16'h8000, 1'b1, 2'b00})
      $display("FAIL ovf_result: data=%h ovf=%0b err=%b, want 8000 1 00", got.data, got.ovf, got.err);
    else n_pass++;
  endtask

  task automatic test_underflow();
    tok_t q[$];
    res_t got;
    bit ok;
    int p0, q0;
    p0 = push_cnt;
    q0 = pop_cnt;
    q = {mk(K_OPD, 16'd2), mk(K_MUL, '0), mk(K_OPD, 16'd5), mk(K_END, '0)};
    run_expr(q, 1, 1, got, ok);
    n_checks++;
    if (got.err !== 2'b01 || got.data !== '0)
      $display("FAIL underflow_result: err=%b data=%h, want 01 0000", got.err, got.data);
    else n_pass++;
    n_checks++;
    if (push_cnt - p0 != 1 || pop_cnt - q0 != 1 || alu_sp !== 4'd0)
      $display("FAIL underflow_drain: pushes=%0d pops=%0d sp=%0d, want 1 1 0",
               push_cnt - p0, pop_cnt - q0, alu_sp);
    else n_pass++;
  endtask

  task automatic test_stack_full();
    tok_t q[$];
    res_t got;
    bit ok;
    int p0, q0;
    p0 = push_cnt;
    q0 = pop_cnt;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(mk(K_OPD, N'(i + 1)));
    q.push_back(mk(K_END, '0));
    run_expr(q, 0, 0, got, ok);
    n_checks++;
    if (got.err !== 2'b10 || got.data !== '0)
      $display("FAIL full_result: err=%b data=%h, want 10 0000", got.err, got.data);
    else n_pass++;
    n_checks++;
    if (push_cnt - p0 != 15 || pop_cnt - q0 != 15 || alu_sp !== 4'd0)
      $display("FAIL full_drain: pushes=%0d pops=%0d sp=%0d, want 15 15 0",
               push_cnt - p0, pop_cnt - q0, alu_sp);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    send_tok(mk(K_OPD, 16'd6));
    send_tok(mk(K_OPD, 16'd7));
    send_tok(mk(K_MUL, '0));
    send_tok(mk(K_END, '0));
    wait_result(ok);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 16'd42 || tok_ready !== 1'b0)
        $display("FAIL hold_cycle%0d: rv=%0b data=%h ready=%0b, want 1 002a 0",
                 i, res_valid, res_data, tok_ready);
      else n_pass++;
      @(negedge clk);
    end
    take_result();
    n_checks++;
    if (res_valid !== 1'b0 || res_err !== 2'b00 || res_ovf !== 1'b0 || tok_ready !== 1'b1)
      $display("FAIL hold_release: rv=%0b err=%b ovf=%0b ready=%0b, want 0 00 0 1",
               res_valid, res_err, res_ovf, tok_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    tok_t q[$];
    res_t got;
    bit ok;
    send_tok(mk(K_OPD, 16'd1));
    send_tok(mk(K_OPD, 16'd2));
    send_tok(mk(K_ADD, '0));
    repeat (3) @(negedge clk);
    n_checks++;
    if (alu_opcode !== OP_POP) $display("FAIL pop2_reached: op=%b, want 111", alu_opcode);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tok_ready, alu_opcode, alu_data, res_valid, res_data, res_ovf, res_err} !== '0 || alu_sp !== 4'd0)
      $display("FAIL async_reset: ready=%0b op=%b data=%h rv=%0b sp=%0d, want all 0",
               tok_ready, alu_opcode, alu_data, res_valid, alu_sp);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    q = {mk(K_OPD, 16'd9), mk(K_END, '0)};
    run_expr(q, 0, 0, got, ok);
    n_checks++;
    if (got !== {16'd9, 1'b0, 2'b00})
      $display("FAIL after_reset: data=%h ovf=%0b err=%b, want 0009 0 00", got.data, got.ovf, got.err);
    else n_pass++;
  endtask

  task automatic test_random();
    tok_t q[$];
    res_t got, exp;
    bit ok;
    for (int n = 0; n < 40; n++) begin
      gen_expr(q);
      exp = model(q);
      run_expr(q, 2, $urandom_range(0, 3), got, ok);
      if (ok) begin
        n_checks++;
        if (got.data !== exp.data) $display("FAIL rnd%0d_data: got %h, want %h", n, got.data, exp.data);
        else n_pass++;
        n_checks++;
        if (got.ovf !== exp.ovf) $display("FAIL rnd%0d_ovf: got %0b, want %0b", n, got.ovf, exp.ovf);
        else n_pass++;
        n_checks++;
        if (got.err !== exp.err) $display("FAIL rnd%0d_err: got %b, want %b", n, got.err, exp.err);
        else n_pass++;
      end
      n_checks++;
      if (alu_sp !== 4'd0) $display("FAIL rnd%0d_depth: sp=%0d, want 0", n, alu_sp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_overflow();
    test_underflow();
    test_stack_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
